// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ARM-style pipeline control from Execute through Writeback, with condition evaluation, flags and event counters
module pipe_ctrl #(
    parameter int ALUCTL_W   = 4,
    parameter int MEM_STAGES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ValidD,
    input  logic [3:0]          CondD,
    input  logic                PCSrcD,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                BranchD,
    input  logic                ALUSrcD,
    input  logic [1:0]          FlagWriteD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [3:0]          ALUFlags,
    input  logic                FlushE,
    input  logic                StallE,
    input  logic                CntClr,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                ALUSrcE,
    output logic                MemtoRegE,
    output logic                BranchTakenE,
    output logic                CondExE,
    output logic                MemWriteM,
    output logic                RegWriteM,
    output logic                MemtoRegM,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic                PCSrcW,
    output logic                PCWrPendingF,
    output logic [3:0]          FlagsE,
    output logic [CNT_W-1:0]    RetiredCnt,
    output logic [CNT_W-1:0]    SquashCnt
);
    localparam logic [CNT_W-1:0] ONE = 1;

    logic                  r_valid_e, r_pcsrc_e, r_regwrite_e, r_memtoreg_e, r_memwrite_e, r_branch_e, r_alusrc_e;
    logic [3:0]            r_cond_e;
    logic [1:0]            r_flagwrite_e;
    logic [ALUCTL_W-1:0]   r_aluctl_e;
    logic [3:0]            r_flags;
    logic [MEM_STAGES-1:0] r_valid_m, r_pcsrc_m, r_regwrite_m, r_memtoreg_m, r_memwrite_m;
    logic                  r_valid_w, r_regwrite_w, r_memtoreg_w, r_pcsrc_w;
    logic [CNT_W-1:0]      r_retired, r_squash;
    logic                  w_n, w_z, w_c, w_v, w_base, w_condex, w_q;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Execute register: flush clears everything, stall holds, otherwise capture Decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset || (FlushE && !reset)) begin
            {r_valid_e, r_pcsrc_e, r_regwrite_e, r_memtoreg_e, r_memwrite_e, r_branch_e, r_alusrc_e} <= '0;
            r_cond_e      <= '0;
            r_flagwrite_e <= '0;
            r_aluctl_e    <= '0;
        end else if (!StallE) begin
            {r_valid_e, r_pcsrc_e, r_regwrite_e, r_memtoreg_e, r_memwrite_e, r_branch_e, r_alusrc_e} <=
                {ValidD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD};
            r_cond_e      <= CondD;
            r_flagwrite_e <= FlagWriteD;
            r_aluctl_e    <= ALUControlD;
        end
    end

    // Condition codes come in true/inverted pairs, so evaluate the even code and flip on bit 0
    always_comb begin
        case (r_cond_e[3:1])
            3'd0:    w_base = w_z;
            3'd1:    w_base = w_c;
            3'd2:    w_base = w_n;
            3'd3:    w_base = w_v;
            3'd4:    w_base = w_c & ~w_z;
            3'd5:    w_base = (w_n == w_v);
            3'd6:    w_base = ~w_z & (w_n == w_v);
            default: w_base = 1'b1;
        endcase
        w_condex = w_base ^ r_cond_e[0];
    end

    assign w_q = w_condex & r_valid_e & ~StallE;

    // Architectural flags: each half written only by a passing, advancing instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_q) begin
            if (r_flagwrite_e[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (r_flagwrite_e[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Memory stages: M1 takes gated Execute controls (a bubble while stalled), later stages just shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r_valid_m, r_pcsrc_m, r_regwrite_m, r_memtoreg_m, r_memwrite_m} <= '0;
        end else begin
            r_valid_m[0]    <= w_q;
            r_pcsrc_m[0]    <= r_pcsrc_e & w_q;
            r_regwrite_m[0] <= r_regwrite_e & w_q;
            r_memwrite_m[0] <= r_memwrite_e & w_q;
            r_memtoreg_m[0] <= r_memtoreg_e & ~StallE;
            for (int i = 1; i < MEM_STAGES; i++) begin
                r_valid_m[i]    <= r_valid_m[i-1];
                r_pcsrc_m[i]    <= r_pcsrc_m[i-1];
                r_regwrite_m[i] <= r_regwrite_m[i-1];
                r_memwrite_m[i] <= r_memwrite_m[i-1];
                r_memtoreg_m[i] <= r_memtoreg_m[i-1];
            end
        end
    end

    // Writeback register follows the last memory stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r_valid_w, r_regwrite_w, r_memtoreg_w, r_pcsrc_w} <= '0;
        end else begin
            {r_valid_w, r_regwrite_w, r_memtoreg_w, r_pcsrc_w} <= {r_valid_m[MEM_STAGES-1],
                r_regwrite_m[MEM_STAGES-1], r_memtoreg_m[MEM_STAGES-1], r_pcsrc_m[MEM_STAGES-1]};
        end
    end

    // Saturating event counters; clear takes priority over counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
            r_squash  <= '0;
        end else if (CntClr) begin
            r_retired <= '0;
            r_squash  <= '0;
        end else begin
            if (r_valid_w && !(&r_retired)) r_retired <= r_retired + ONE;
            if (r_valid_e && !StallE && !w_condex && !(&r_squash)) r_squash <= r_squash + ONE;
        end
    end

    assign ALUControlE  = r_aluctl_e;
    assign ALUSrcE      = r_alusrc_e;
    assign MemtoRegE    = r_memtoreg_e;
    assign BranchTakenE = r_branch_e & w_q;
    assign CondExE      = w_condex;
    assign MemWriteM    = r_memwrite_m[MEM_STAGES-1];
    assign RegWriteM    = r_regwrite_m[MEM_STAGES-1];
    assign MemtoRegM    = r_memtoreg_m[MEM_STAGES-1];
    assign RegWriteW    = r_regwrite_w;
    assign MemtoRegW    = r_memtoreg_w;
    assign PCSrcW       = r_pcsrc_w;
    assign PCWrPendingF = PCSrcD | r_pcsrc_e | (|r_pcsrc_m);
    assign FlagsE       = r_flags;
    assign RetiredCnt   = r_retired;
    assign SquashCnt    = r_squash;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl at memory depths 1, 2 and 3 with 4-bit counters
module tb_pipe_ctrl;
    logic       clk, reset;
    logic       v_d, pcsrc_d, rw_d, m2r_d, mw_d, br_d, alusrc_d, flush, stall, cclr;
    logic [3:0] cond_d, alu_d, aluf;
    logic [1:0] fw_d;

    logic [3:0]  alu_e [3];
    logic        alusrc_e [3], m2r_e [3], bt_e [3], cex_e [3];
    logic        mw_m [3], rw_m [3], m2r_m [3], rw_w [3], m2r_w [3], pc_w [3], pend [3];
    logic [3:0]  flags [3], ret [3], sq [3];
    logic [26:0] all_out [3];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] fl;
        logic [3:0] cond;
        logic       exp;
    } vec_t;
    vec_t tbl [19];

    for (genvar g = 0; g < 3; g++) begin : gd
        pipe_ctrl #(.ALUCTL_W(4), .MEM_STAGES(g + 1), .CNT_W(4)) u (
            .clk(clk), .reset(reset), .ValidD(v_d), .CondD(cond_d), .PCSrcD(pcsrc_d),
            .RegWriteD(rw_d), .MemtoRegD(m2r_d), .MemWriteD(mw_d), .BranchD(br_d),
            .ALUSrcD(alusrc_d), .FlagWriteD(fw_d), .ALUControlD(alu_d), .ALUFlags(aluf),
            .FlushE(flush), .StallE(stall), .CntClr(cclr),
            .ALUControlE(alu_e[g]), .ALUSrcE(alusrc_e[g]), .MemtoRegE(m2r_e[g]),
            .BranchTakenE(bt_e[g]), .CondExE(cex_e[g]), .MemWriteM(mw_m[g]), .RegWriteM(rw_m[g]),
            .MemtoRegM(m2r_m[g]), .RegWriteW(rw_w[g]), .MemtoRegW(m2r_w[g]), .PCSrcW(pc_w[g]),
            .PCWrPendingF(pend[g]), .FlagsE(flags[g]), .RetiredCnt(ret[g]), .SquashCnt(sq[g])
        );
        assign all_out[g] = {alu_e[g], alusrc_e[g], m2r_e[g], bt_e[g], cex_e[g], mw_m[g], rw_m[g],
                             m2r_m[g], rw_w[g], m2r_w[g], pc_w[g], pend[g], flags[g], ret[g], sq[g]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {v_d, pcsrc_d, rw_d, m2r_d, mw_d, br_d, alusrc_d} = '0;
        cond_d = '0;
        alu_d  = '0;
        fw_d   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        {flush, stall, cclr} = '0;
        aluf = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'b0000, 4'h0, 1'b0};
        tbl[1]  = '{4'b0100, 4'h0, 1'b1};
        tbl[2]  = '{4'b0100, 4'h1, 1'b0};
        tbl[3]  = '{4'b0010, 4'h2, 1'b1};
        tbl[4]  = '{4'b0010, 4'h3, 1'b0};
        tbl[5]  = '{4'b1000, 4'h4, 1'b1};
        tbl[6]  = '{4'b0000, 4'h5, 1'b1};
        tbl[7]  = '{4'b0001, 4'h6, 1'b1};
        tbl[8]  = '{4'b0001, 4'h7, 1'b0};
        tbl[9]  = '{4'b0010, 4'h8, 1'b1};
        tbl[10] = '{4'b0110, 4'h8, 1'b0};
        tbl[11] = '{4'b0110, 4'h9, 1'b1};
        tbl[12] = '{4'b1001, 4'hA, 1'b1};
        tbl[13] = '{4'b1000, 4'hB, 1'b1};
        tbl[14] = '{4'b0000, 4'hC, 1'b1};
        tbl[15] = '{4'b0100, 4'hC, 1'b0};
        tbl[16] = '{4'b1000, 4'hD, 1'b1};
        tbl[17] = '{4'b0000, 4'hE, 1'b1};
        tbl[18] = '{4'b0000, 4'hF, 1'b0};

        reset = 1'b1;
        idle();
        {flush, stall, cclr} = '0;
        aluf = '0;
        #2;
        for (int g = 0; g < 3; g++) chk("reset_outputs_zero", 32'(all_out[g]), 0);
        tick();
        reset = 1'b0;

        // condition table: load flags with an AL flag-writer, then evaluate a branch against them
        for (int i = 0; i < 19; i++) begin
            idle();
            v_d = 1'b1; cond_d = 4'hE; fw_d = 2'b11;
            tick();
            idle();
            aluf = tbl[i].fl;
            v_d = 1'b1; cond_d = tbl[i].cond; br_d = 1'b1; alu_d = tbl[i].cond;
            tick();
            chk("tbl_flags", 32'(flags[0]), 32'(tbl[i].fl));
            chk("tbl_condex", 32'(cex_e[0]), 32'(tbl[i].exp));
            chk("tbl_branch_taken", 32'(bt_e[0]), 32'(tbl[i].exp));
            chk("tbl_aluctl", 32'(alu_e[0]), 32'(tbl[i].cond));
            chk("tbl_condex_d3", 32'(cex_e[2]), 32'(tbl[i].exp));
        end

        // conditional skip with flags cleared, then a passing RegWrite retires
        do_reset();
        v_d = 1'b1; cond_d = 4'h0; rw_d = 1'b1;
        tick();
        chk("skip_condex", 32'(cex_e[0]), 0);
        idle();
        tick();
        chk("skip_regwrite_m", 32'(rw_m[0]), 0);
        chk("skip_squash", 32'(sq[0]), 1);
        tick();
        tick();
        chk("skip_regwrite_w", 32'(rw_w[0]), 0);
        chk("skip_retired", 32'(ret[0]), 0);
        v_d = 1'b1; cond_d = 4'hE; rw_d = 1'b1;
        tick();
        idle();
        tick();
        chk("pass_regwrite_m", 32'(rw_m[0]), 1);
        tick();
        chk("pass_regwrite_w", 32'(rw_w[0]), 1);
        tick();
        chk("pass_retired", 32'(ret[0]), 1);
        chk("pass_squash", 32'(sq[0]), 1);

        // split flag write then GT with Z set
        do_reset();
        v_d = 1'b1; cond_d = 4'hE; fw_d = 2'b10; aluf = 4'hF;
        tick();
        idle();
        tick();
        chk("split_flags", 32'(flags[0]), 32'b1100);
        v_d = 1'b1; cond_d = 4'hC; br_d = 1'b1;
        tick();
        chk("gt_branch_taken", 32'(bt_e[0]), 0);
        chk("gt_condex", 32'(cex_e[0]), 0);

        // stall and flush interplay
        do_reset();
        v_d = 1'b1; cond_d = 4'hE; mw_d = 1'b1;
        tick();
        idle();
        tick();
        chk("mw_pass_m", 32'(mw_m[0]), 1);
        tick();
        tick();
        v_d = 1'b1; cond_d = 4'hE; mw_d = 1'b1;
        tick();
        idle();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_bubble_mw", 32'(mw_m[0]), 0);
            chk("stall_no_squash", 32'(sq[0]), 0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int g = 0; g < 3; g++) chk("flush_no_mw", 32'(mw_m[g]), 0);
        end
        chk("flush_retired", 32'(ret[0]), 1);

        // PC-write pending window and writeback latency for each depth
        do_reset();
        v_d = 1'b1; cond_d = 4'hE; pcsrc_d = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) chk("pend_d", 32'(pend[g]), 1);
        tick();
        idle();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            #1;
            for (int g = 0; g < 3; g++) begin
                chk("pend_window", 32'(pend[g]), 32'(k <= g + 2));
                chk("pcsrc_w_latency", 32'(pc_w[g]), 32'(k == g + 3));
            end
        end

        // retire counter saturation and clear priority
        do_reset();
        v_d = 1'b1; cond_d = 4'hE;
        for (int k = 0; k < 10; k++) tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        for (int g = 0; g < 3; g++) chk("retired_10", 32'(ret[g]), 10);
        v_d = 1'b1; cond_d = 4'hE;
        for (int k = 0; k < 7; k++) tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        for (int g = 0; g < 3; g++) chk("retired_sat", 32'(ret[g]), 15);
        v_d = 1'b1; cond_d = 4'hE;
        tick();
        idle();
        tick();
        tick();
        cclr = 1'b1;
        tick();
        cclr = 1'b0;
        chk("clr_vs_retire", 32'(ret[0]), 0);
        tick();
        chk("clr_after", 32'(ret[0]), 0);
        chk("clr_squash", 32'(sq[0]), 0);

        // async reset between edges with three instructions in flight
        do_reset();
        v_d = 1'b1; cond_d = 4'hE; rw_d = 1'b1; mw_d = 1'b1; pcsrc_d = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        idle();
        #1;
        chk("inflight_pend", 32'(pend[2]), 1);
        #1;
        reset = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) chk("async_reset_zero", 32'(all_out[g]), 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        for (int g = 0; g < 3; g++) begin
            chk("post_reset_retired", 32'(ret[g]), 0);
            chk("post_reset_squash", 32'(sq[g]), 0);
            chk("post_reset_outputs", 32'(all_out[g]), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ALUCTL_W, default 4: width of the ALU control field.
REQ-002 Parameter MEM_STAGES, default 1, legal range 1..3: number of memory-stage registers between Execute and Writeback.
REQ-003 Parameter CNT_W, default 16: width of each event counter.
REQ-004 Clock and reset SHALL be: one clock, `clk`, rising edge; reset is `reset`, asynchronous and active-high; all state clears on `reset`=1.
REQ-005 Inputs SHALL be:
- ValidD (1): Decode slot holds a real instruction.
- CondD (4): ARM condition field.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD (1 each): decoded controls.
- FlagWriteD (2): bit1 = write N,Z; bit0 = write C,V.
- ALUControlD (ALUCTL_W): ALU operation.
- ALUFlags (4): {N,Z,C,V} from the ALU in Execute.
- FlushE (1): load a bubble into Execute.
- StallE (1): hold Execute.
- CntClr (1): synchronous counter clear.
REQ-006 Outputs SHALL be:
- ALUControlE (ALUCTL_W), ALUSrcE (1), MemtoRegE (1), BranchTakenE (1), CondExE (1): Execute stage.
- MemWriteM, RegWriteM, MemtoRegM (1 each): final memory stage.
- RegWriteW, MemtoRegW, PCSrcW (1 each): Writeback stage.
- PCWrPendingF (1): PC-write hazard.
- FlagsE (4): architectural flags.
- RetiredCnt (CNT_W): count of retired instructions.
- SquashCnt (CNT_W): count of squashed instructions.

Function
REQ-007 The Execute register SHALL capture all D-stage controls plus ValidD and CondD each cycle when FlushE=0 and StallE=0 (1-cycle D->E latency).
REQ-008 FlushE=1 SHALL load zeros into every Execute control bit including valid; FlushE wins over StallE.
REQ-009 StallE=1 with FlushE=0 SHALL hold the Execute register.
- While stalled, the first memory stage SHALL receive a bubble (all enables and valid 0).
- While stalled, flags SHALL NOT update and counters SHALL NOT increment.
REQ-010 CondExE SHALL be the ARM condition result of CondE against FlagsE, evaluated combinationally:
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
- 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
- E AL 1; F 0.
REQ-011 Gating by qualifier q = CondExE & ValidE & !StallE:
- BranchTakenE = BranchE & q.
- Forwarded PCSrc, RegWrite and MemWrite SHALL each equal the Execute value ANDed with q.
- MemtoReg SHALL pass ungated.
REQ-012 FlagsE SHALL update on the clock edge with q=1:
- N,Z from ALUFlags[3:2] when FlagWriteE[1]=1.
- C,V from ALUFlags[1:0] when FlagWriteE[0]=1.
- All other edges hold FlagsE.
REQ-013 Memory pipeline: MEM_STAGES chained registers M1..Mn with no stall or flush; M-named outputs SHALL come from Mn (E->Mn latency = MEM_STAGES cycles).
REQ-014 Writeback register SHALL follow Mn by exactly 1 cycle.
REQ-015 PCWrPendingF SHALL be combinational: PCSrcD | PCSrcE | OR of the PCSrc bit in every M stage.
REQ-016 Valid propagates with the gated controls. RetiredCnt SHALL increment by 1 on each edge where W-stage valid=1 and that instruction's condition passed.
REQ-017 SquashCnt SHALL increment by 1 on each edge where ValidE=1, StallE=0 and CondExE=0.
REQ-018 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-019 CntClr=1 SHALL zero both counters on the next edge; clear wins over a simultaneous increment.
REQ-020 Pipeline advance is not blocked by CntClr or saturation.

Reset
REQ-021 reset=1 SHALL immediately zero:
- every pipeline register, including all valid bits;
- FlagsE, RetiredCnt and SquashCnt;
- therefore every output, including PCWrPendingF when PCSrcD=0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight instructions without counting them.
REQ-023 The first capture after reset deassertion SHALL occur on the first rising edge with reset=0.

Verification
REQ-024 Conditional skip: FlagsE=0000, issue CondD=0 (EQ), RegWriteD=1, ValidD=1 -> RegWriteM=0, SquashCnt=1, RetiredCnt unchanged.
REQ-025 Split flag write: ALUFlags=1111, FlagWriteD=10, CondD=E -> FlagsE=1100 one cycle after Execute. Then CondD=C (GT) with BranchD=1 -> BranchTakenE=0.
REQ-026 Stall/flush interplay: hold StallE=1 for 3 cycles with a valid MemWriteD=1 in Execute -> bubbles enter M1. Then assert FlushE=1 together with StallE=1 -> Execute is cleared and MemWriteM never asserts.
REQ-027 Depth sweep at MEM_STAGES=1,2,3: a single PCSrcD=1 pulse -> PCWrPendingF high for exactly 2+MEM_STAGES cycles; PCSrcW=1 appears 2+MEM_STAGES cycles after D.
REQ-028 Counter boundaries at CNT_W=4: retire 17 instructions -> RetiredCnt=15. CntClr coincident with a retire -> RetiredCnt=0.
REQ-029 Async reset asserted between edges with 3 valid instructions in flight -> all outputs are 0 before the next edge, and both counters remain 0 after release.
